code_word_tx: RTL and testbench



---
 rtl/code_word_pkg.sv | 21 ++
 rtl/code_word_timer.sv | 39 +++
 rtl/code_word_tx.sv | 167 ++++++++++++++++
 tb/tb_code_word_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/code_word_pkg.sv
// Shared types and constants for the code-word transmitter.
package code_word_pkg;

    // One code word as presented on the {a,b,c,d} lines.
    typedef logic [3:0] word_t;

    // Transmitter phases: waiting for a word, holding it on the lines,
    // then driving the idle gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The word the downstream comparator matches against.
    localparam word_t CODE_KEY = 4'b0101;

    // Width of the hold/gap window counter; covers window lengths up to 255.
    localparam int TIMER_W = 8;

endpackage : code_word_pkg

// File: rtl/code_word_timer.sv
// Loadable down-counter with a zero flag. The transmitter loads it with
// (window length - 1) on entry to a window and lets it count down; the
// window ends on the cycle the counter reads zero. It stops at zero.
module code_word_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over counting, and counting stops at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : code_word_timer

// File: rtl/code_word_tx.sv
// Transmit side of the 4-bit constant comparator link. Words arrive on a
// valid/ready handshake, are held on {a,b,c,d} for HOLD_CYCLES cycles and
// are followed by GAP_CYCLES cycles of 0000. Every output is a register.
// Optional feature macro: CODE_WORD_KEY_COUNT_EN enables the saturating
// count of transmitted words equal to KEY; without it key_count is 0.
module code_word_tx
    import code_word_pkg::*;
#(
    parameter word_t KEY         = CODE_KEY,
    parameter int    HOLD_CYCLES = 2,
    parameter int    GAP_CYCLES  = 1,
    parameter int    CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_word,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             out_strobe,
    output logic             busy,
    output logic [CNT_W-1:0] key_count
);

    // Counter load values are window length minus one, since the timer's
    // zero cycle is itself the last cycle of the window.
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  =
        (GAP_CYCLES == 0) ? '0 : TIMER_W'(GAP_CYCLES - 1);

    state_t state_q;
    state_t state_d;
    word_t  lines_q;
    word_t  lines_d;
    logic   strobe_q;
    logic   strobe_d;
    logic   busy_q;
    logic   busy_d;
    logic   in_ready_q;
    logic   in_ready_d;

    logic   accept;
    logic   timer_load;
    logic   timer_en;
    logic   timer_zero;
    logic [TIMER_W-1:0] timer_load_val;

    // A word is taken only while the registered ready is high.
    assign accept = in_valid && in_ready_q;

    code_word_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // Next state, timer control and next values of the registered outputs.
    always_comb begin
        state_d        = state_q;
        lines_d        = '0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d        = DRIVE;
                    lines_d        = in_word;
                    timer_load     = 1'b1;
                    timer_load_val = HOLD_LOAD;
                end
            end
            DRIVE: begin
                if (timer_zero) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d        = GAP;
                        timer_load     = 1'b1;
                        timer_load_val = GAP_LOAD;
                    end
                end else begin
                    lines_d  = lines_q;
                    timer_en = 1'b1;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    state_d = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        strobe_d   = accept;
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lines_q    <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lines_q    <= lines_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign a          = lines_q[3];
    assign b          = lines_q[2];
    assign c          = lines_q[1];
    assign d          = lines_q[0];
    assign out_strobe = strobe_q;
    assign busy       = busy_q;
    assign in_ready   = in_ready_q;

`ifdef CODE_WORD_KEY_COUNT_EN
    logic [CNT_W-1:0] key_count_q;
    logic [CNT_W-1:0] key_count_d;

    // Count accepted key words, sticking at the all-ones value.
    always_comb begin
        key_count_d = key_count_q;
        if (accept && (in_word == KEY) && (key_count_q != {CNT_W{1'b1}})) begin
            key_count_d = key_count_q + CNT_W'(1);
        end
    end

    // Key counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_count_q <= '0;
        end else begin
            key_count_q <= key_count_d;
        end
    end

    assign key_count = key_count_q;
`else
    // KEY has no consumer when counting is compiled out.
    logic unused_key;
    assign unused_key = ^KEY;
    assign key_count  = '0;
`endif

endmodule : code_word_tx

// File: tb/tb_code_word_tx.sv
// Directed testbench for code_word_tx: a cycle table for the default
// configuration plus short hand sequences for the zero-gap and saturation
// configurations and a reset in the middle of a word.
module tb_code_word_tx;

`ifdef CODE_WORD_KEY_COUNT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Default configuration: HOLD=2, GAP=1, CNT_W=8.
    logic       main_valid;
    logic [3:0] main_word;
    logic       main_ready, main_a, main_b, main_c, main_d;
    logic       main_strobe, main_busy;
    logic [7:0] main_key;

    // Zero-gap configuration: HOLD=1, GAP=0.
    logic       fast_valid;
    logic [3:0] fast_word;
    logic       fast_ready, fast_a, fast_b, fast_c, fast_d;
    logic       fast_strobe, fast_busy;
    logic [7:0] fast_key;

    // Narrow counter configuration: HOLD=1, GAP=0, CNT_W=2.
    logic       sat_valid;
    logic [3:0] sat_word;
    logic       sat_ready, sat_a, sat_b, sat_c, sat_d;
    logic       sat_strobe, sat_busy;
    logic [1:0] sat_key;

    int n_compared;
    int n_mismatched;

    code_word_tx #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .CNT_W(8)) dut_main (
        .clk(clk), .rst_n(rst_n), .in_valid(main_valid), .in_ready(main_ready),
        .in_word(main_word), .a(main_a), .b(main_b), .c(main_c), .d(main_d),
        .out_strobe(main_strobe), .busy(main_busy), .key_count(main_key)
    );

    code_word_tx #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_fast (
        .clk(clk), .rst_n(rst_n), .in_valid(fast_valid), .in_ready(fast_ready),
        .in_word(fast_word), .a(fast_a), .b(fast_b), .c(fast_c), .d(fast_d),
        .out_strobe(fast_strobe), .busy(fast_busy), .key_count(fast_key)
    );

    code_word_tx #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(sat_valid), .in_ready(sat_ready),
        .in_word(sat_word), .a(sat_a), .b(sat_b), .c(sat_c), .d(sat_d),
        .out_strobe(sat_strobe), .busy(sat_busy), .key_count(sat_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       valid;
        logic [3:0] word;
        logic [3:0] lines;
        logic       strobe;
        logic       busy;
        logic       ready;
        logic [7:0] key;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive the default DUT for one edge, then compare right after it.
    task automatic applyStimulus(input logic valid, input logic [3:0] word);
        main_valid = valid;
        main_word  = word;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic [3:0] lines, input logic strobe,
                             input logic busy, input logic ready, input logic [7:0] key);
        checkOutput({tag, " lines"},  {28'd0, main_a, main_b, main_c, main_d}, {28'd0, lines});
        checkOutput({tag, " strobe"}, {31'd0, main_strobe}, {31'd0, strobe});
        checkOutput({tag, " busy"},   {31'd0, main_busy},   {31'd0, busy});
        checkOutput({tag, " ready"},  {31'd0, main_ready},  {31'd0, ready});
        checkOutput({tag, " key"},    {24'd0, main_key},    {24'd0, KEY_EN ? key : 8'd0});
    endtask

    task automatic stepFast(input string tag, input logic valid, input logic [3:0] word,
                            input logic [3:0] lines, input logic strobe,
                            input logic busy, input logic ready);
        fast_valid = valid;
        fast_word  = word;
        @(posedge clk);
        #1;
        checkOutput({tag, " lines"},  {28'd0, fast_a, fast_b, fast_c, fast_d}, {28'd0, lines});
        checkOutput({tag, " strobe"}, {31'd0, fast_strobe}, {31'd0, strobe});
        checkOutput({tag, " busy"},   {31'd0, fast_busy},   {31'd0, busy});
        checkOutput({tag, " ready"},  {31'd0, fast_ready},  {31'd0, ready});
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n      = 1'b0;
        main_valid = 1'b0; main_word = 4'h0;
        fast_valid = 1'b0; fast_word = 4'h0;
        sat_valid  = 1'b0; sat_word  = 4'h0;

        // valid, word, lines, strobe, busy, ready, key (after the edge)
        vecs[0]  = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0};  // ready rises
        vecs[1]  = '{1'b1, 4'h5, 4'b0101, 1'b1, 1'b1, 1'b0, 8'd1};  // accept key
        vecs[2]  = '{1'b0, 4'h0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[3]  = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};  // gap
        vecs[4]  = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1};  // idle
        vecs[5]  = '{1'b1, 4'h5, 4'b0101, 1'b1, 1'b1, 1'b0, 8'd2};  // back-to-back #1
        vecs[6]  = '{1'b1, 4'hA, 4'b0101, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[7]  = '{1'b1, 4'hA, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[8]  = '{1'b1, 4'hA, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[9]  = '{1'b1, 4'hA, 4'b1010, 1'b1, 1'b1, 1'b0, 8'd2};  // back-to-back #2
        vecs[10] = '{1'b1, 4'h5, 4'b1010, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[11] = '{1'b1, 4'h5, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[12] = '{1'b1, 4'h5, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[13] = '{1'b1, 4'h5, 4'b0101, 1'b1, 1'b1, 1'b0, 8'd3};  // back-to-back #3
        vecs[14] = '{1'b0, 4'h0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[15] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[16] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd3};
        vecs[17] = '{1'b1, 4'h3, 4'b0011, 1'b1, 1'b1, 1'b0, 8'd3};  // non-key word
        vecs[18] = '{1'b1, 4'h5, 4'b0011, 1'b0, 1'b1, 1'b0, 8'd3};  // ignored while busy
        vecs[19] = '{1'b0, 4'hF, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[20] = '{1'b1, 4'h5, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd3};  // not taken: ready was 0
        vecs[21] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd3};

        // Reset state while rst_n is held low.
        #12;
        checkMain("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);

        // Release between edges; ready must follow on the next edge.
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].word);
            checkMain($sformatf("vec%0d", i), vecs[i].lines, vecs[i].strobe,
                      vecs[i].busy, vecs[i].ready, vecs[i].key);
        end
        main_valid = 1'b0;

        // Zero gap, one-cycle hold: accepts two cycles apart, never a GAP cycle.
        stepFast("fast acc0",  1'b1, 4'h5, 4'b0101, 1'b1, 1'b1, 1'b0);
        stepFast("fast idle0", 1'b1, 4'h3, 4'b0000, 1'b0, 1'b0, 1'b1);
        stepFast("fast acc1",  1'b1, 4'h3, 4'b0011, 1'b1, 1'b1, 1'b0);
        stepFast("fast idle1", 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("fast key", {24'd0, fast_key}, KEY_EN ? 32'd1 : 32'd0);

        // Five key words into a 2-bit counter: accepts on every other edge.
        sat_valid = 1'b1;
        sat_word  = 4'h5;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sat key after 2", {30'd0, sat_key}, KEY_EN ? 32'd2 : 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("sat key after 5", {30'd0, sat_key}, KEY_EN ? 32'd3 : 32'd0);
        checkOutput("sat lines", {28'd0, sat_a, sat_b, sat_c, sat_d}, 32'd0);
        sat_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a 1111 word.
        applyStimulus(1'b1, 4'hF);
        checkOutput("mid lines before reset", {28'd0, main_a, main_b, main_c, main_d}, 32'hF);
        main_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkMain("mid reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkMain("post reset", 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0);
        @(posedge clk);
        #1;
        checkMain("post reset+1", 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_code_word_tx
